div_sign_adapter: RTL and testbench
===================================

Name: div_sign_adapter

Overview:
- Front-end stage that sits directly upstream of the 64-bit unsigned shift-subtract divider core and its control FSM.
- Accepts signed or unsigned operand pairs over a valid/ready handshake and converts them to magnitudes.
- Launches the core with a one-cycle start pulse, tracks the core's ready handshake, and applies sign correction to the returned quotient/remainder.
- Handles divide-by-zero without the core, provides a watchdog timeout, and presents results on a valid/ready output port.

Parameters:
- WIDTH, 64, operand/result width; must equal the divider core width.
- TIMEOUT_CYCLES, 100, maximum cycles from core_start to core ready-return before the operation is aborted.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset (asserted when 0)
- in_valid  input  1  operand pair valid
- in_ready  output  1  adapter can accept an operand pair
- in_signed  input  1  1 = two's-complement operation, 0 = unsigned
- in_dividend  input  WIDTH  dividend
- in_divisor  input  WIDTH  divisor
- core_start  output  1  one-cycle launch pulse to the divider core
- core_ready  input  1  core idle indicator
- core_dividend  output  WIDTH  magnitude of dividend, held stable from LAUNCH until capture
- core_divisor  output  WIDTH  magnitude of divisor, held stable from LAUNCH until capture
- core_quotient  input  WIDTH  unsigned quotient from core
- core_remainder  input  WIDTH  unsigned remainder from core
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_quotient  output  WIDTH  final quotient
- out_remainder  output  WIDTH  final remainder
- out_div_zero  output  1  result came from the divide-by-zero path
- out_timeout  output  1  result came from a watchdog abort

Behaviour:
- Reset (reset==0 at a clock edge):
  - State returns to IDLE; the watchdog counter clears.
  - All outputs go to 0, except in_ready, which is 1 in IDLE.
  - Reset overrides everything, including mid-operation; the core is not separately reset by this block.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid, latch in_signed, the operand signs, and the operand magnitudes.
  - Magnitude = two's-complement negation when signed and MSB=1, else the raw value. Signed -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
  - If in_divisor==0, go to OUT with out_quotient = all ones, out_remainder = raw in_dividend, out_div_zero=1. The core is never started.
  - Otherwise go to LAUNCH.
- LAUNCH:
  - core_start = core_ready (combinational, only in this state).
  - On the cycle core_start=1, clear the watchdog and go to WAIT_BUSY; otherwise remain in LAUNCH.
- WAIT_BUSY: wait for core_ready==0, then go to WAIT_DONE.
- WAIT_DONE:
  - When core_ready==1, capture the core results with sign correction into the output registers and go to OUT.
- Watchdog:
  - Increments every cycle in WAIT_BUSY and WAIT_DONE.
  - Reaching TIMEOUT_CYCLES forces OUT with quotient=0, remainder=0, out_timeout=1.
- Sign correction (signed ops only):
  - Quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
  - A zero result stays zero.
  - Unsigned ops pass the core results through unchanged.
- Overflow: signed MIN / -1 yields quotient = MIN and remainder = 0 via the normal path (2^63/1 = 2^63, negation wraps). No flag is raised.
- OUT:
  - out_valid=1; outputs are held stable while out_ready==0.
  - On out_ready, go to IDLE and clear the flags.
  - in_ready=0 in every state except IDLE, so there is no accept-while-outputting.
- Latency with a core of 1 load + 64 op cycles and core_ready high at acceptance:
  - Acceptance at cycle 0; core_start at cycle 1.
  - Capture at cycle 67; out_valid at cycle 68.
  - Divide-by-zero: out_valid at cycle 1.
- A core_ready glitch high in WAIT_BUSY is ignored; only a 0 advances the state.

Test Plan:
- Unsigned 100/7, in_signed=0 -> out_quotient=14, out_remainder=2, out_valid asserted 68 cycles after acceptance, core_start a single-cycle pulse.
- Signed -100/7 -> quotient -14 (0xFFFF_FFFF_FFFF_FFF2), remainder -2. Signed 100/-7 -> quotient -14, remainder 2. Signed -100/-7 -> quotient 14, remainder -2.
- Divisor 0 with dividend 0x1234 -> quotient all ones, remainder 0x1234, out_div_zero=1, out_valid at cycle 1, core_start never asserted.
- Signed 0x8000_0000_0000_0000 / -1 -> quotient 0x8000_0000_0000_0000, remainder 0. Unsigned 0xFFFF_FFFF_FFFF_FFFF/1 -> quotient all ones, remainder 0.
- out_ready held low for 10 cycles after out_valid -> outputs stable and in_ready=0 throughout; pulsing in_valid is not accepted until after the handshake.
- core_ready stuck low after start -> out_timeout=1 with zero results at TIMEOUT_CYCLES. Separately, reset=0 asserted in WAIT_DONE -> next cycle IDLE, in_ready=1, out_valid=0.

Source files
------------

// File: rtl/div_sign_adapter.sv
// rtl/div_sign_adapter.sv - signed/unsigned front-end for the unsigned shift-subtract divider core
module div_sign_adapter #(
    parameter int WIDTH          = 64,
    parameter int TIMEOUT_CYCLES = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             core_start,
    input  logic             core_ready,
    output logic [WIDTH-1:0] core_dividend,
    output logic [WIDTH-1:0] core_divisor,
    input  logic [WIDTH-1:0] core_quotient,
    input  logic [WIDTH-1:0] core_remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_div_zero,
    output logic             out_timeout
);

    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_OUT
    } state_t;

    state_t           state_q, state_d;
    logic             signed_q, signed_d;
    logic             dvd_neg_q, dvd_neg_d;
    logic             dvs_neg_q, dvs_neg_d;
    logic [WIDTH-1:0] dvd_mag_q, dvd_mag_d;
    logic [WIDTH-1:0] dvs_mag_q, dvs_mag_d;
    logic [WDW-1:0]   wdog_q, wdog_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             div_zero_q, div_zero_d;
    logic             timeout_q, timeout_d;

    logic [WDW-1:0]   wdog_inc;
    logic             wdog_expired;
    logic             neg_quot;
    logic             neg_rem;

    assign wdog_inc     = wdog_q + WDW'(1);
    assign wdog_expired = (wdog_inc >= WD_LIMIT);
    assign neg_quot     = signed_q & (dvd_neg_q ^ dvs_neg_q);
    assign neg_rem      = signed_q & dvd_neg_q;

    always_comb begin
        state_d    = state_q;
        signed_d   = signed_q;
        dvd_neg_d  = dvd_neg_q;
        dvs_neg_d  = dvs_neg_q;
        dvd_mag_d  = dvd_mag_q;
        dvs_mag_d  = dvs_mag_q;
        wdog_d     = wdog_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        div_zero_d = div_zero_q;
        timeout_d  = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    signed_d  = in_signed;
                    dvd_neg_d = in_signed & in_dividend[WIDTH-1];
                    dvs_neg_d = in_signed & in_divisor[WIDTH-1];
                    // Negating MIN wraps back to MIN, which reads as 2^(WIDTH-1) unsigned
                    dvd_mag_d = (in_signed & in_dividend[WIDTH-1]) ? -in_dividend : in_dividend;
                    dvs_mag_d = (in_signed & in_divisor[WIDTH-1])  ? -in_divisor  : in_divisor;
                    if (in_divisor == '0) begin
                        quot_d     = '1;
                        rem_d      = in_dividend;
                        div_zero_d = 1'b1;
                        timeout_d  = 1'b0;
                        state_d    = S_OUT;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                if (core_ready) begin
                    wdog_d  = '0;
                    state_d = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                wdog_d = wdog_inc;
                if (wdog_expired) begin
                    quot_d    = '0;
                    rem_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = S_OUT;
                end else if (!core_ready) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                wdog_d = wdog_inc;
                // A returning core wins over a watchdog expiring on the same cycle
                if (core_ready) begin
                    quot_d  = neg_quot ? -core_quotient  : core_quotient;
                    rem_d   = neg_rem  ? -core_remainder : core_remainder;
                    state_d = S_OUT;
                end else if (wdog_expired) begin
                    quot_d    = '0;
                    rem_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    div_zero_d = 1'b0;
                    timeout_d  = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            signed_q   <= 1'b0;
            dvd_neg_q  <= 1'b0;
            dvs_neg_q  <= 1'b0;
            dvd_mag_q  <= '0;
            dvs_mag_q  <= '0;
            wdog_q     <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            div_zero_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            signed_q   <= signed_d;
            dvd_neg_q  <= dvd_neg_d;
            dvs_neg_q  <= dvs_neg_d;
            dvd_mag_q  <= dvd_mag_d;
            dvs_mag_q  <= dvs_mag_d;
            wdog_q     <= wdog_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            div_zero_q <= div_zero_d;
            timeout_q  <= timeout_d;
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign out_valid     = (state_q == S_OUT);
    assign core_start    = (state_q == S_LAUNCH) & core_ready;
    assign core_dividend = dvd_mag_q;
    assign core_divisor  = dvs_mag_q;
    assign out_quotient  = quot_q;
    assign out_remainder = rem_q;
    assign out_div_zero  = div_zero_q;
    assign out_timeout   = timeout_q;

endmodule

// File: tb/tb_div_sign_adapter.sv
// tb/tb_div_sign_adapter.sv - directed bench with arithmetic reference model for div_sign_adapter
module tb_div_sign_adapter;

    localparam int W  = 64;
    localparam int TO = 100;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_signed = 1'b0;
    logic [W-1:0] in_dividend = '0;
    logic [W-1:0] in_divisor = '0;
    logic         core_start;
    logic         core_ready;
    logic [W-1:0] core_dividend;
    logic [W-1:0] core_divisor;
    logic [W-1:0] core_quotient;
    logic [W-1:0] core_remainder;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_quotient;
    logic [W-1:0] out_remainder;
    logic         out_div_zero;
    logic         out_timeout;

    always #5 clk = ~clk;

    div_sign_adapter #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_signed     (in_signed),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .core_start    (core_start),
        .core_ready    (core_ready),
        .core_dividend (core_dividend),
        .core_divisor  (core_divisor),
        .core_quotient (core_quotient),
        .core_remainder(core_remainder),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_div_zero  (out_div_zero),
        .out_timeout   (out_timeout)
    );

    // Core stand-in: 1 load + 64 op cycles busy, optionally stuck busy
    logic stuck = 1'b0;
    int   core_cnt;
    always @(posedge clk) begin
        if (!reset) begin
            core_ready     <= 1'b1;
            core_cnt       <= 0;
            core_quotient  <= '0;
            core_remainder <= '0;
        end else if (core_start) begin
            core_ready <= 1'b0;
            core_cnt   <= 65;
        end else if (core_cnt > 1) begin
            core_cnt <= core_cnt - 1;
        end else if (core_cnt == 1 && !stuck) begin
            core_cnt       <= 0;
            core_ready     <= 1'b1;
            core_quotient  <= core_dividend / core_divisor;
            core_remainder <= core_dividend % core_divisor;
        end
    end

    function automatic logic signed [W:0] ext(input logic sg, input logic [W-1:0] v);
        return sg ? {v[W-1], v} : {1'b0, v};
    endfunction

    function automatic logic [W-1:0] mag(input logic signed [W:0] x);
        logic signed [W:0] t;
        t = (x < 0) ? -x : x;
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] sdiv(input logic signed [W:0] a, input logic signed [W:0] b);
        logic signed [W:0] t;
        t = a / b;
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] smod(input logic signed [W:0] a, input logic signed [W:0] b);
        logic signed [W:0] t;
        t = a % b;
        return t[W-1:0];
    endfunction

    // Reference model: pe counts rising edges; an operation accepted at edge m_e
    // shows its result from edge m_vedge onwards until the output handshake.
    int           pe = 0;
    logic         m_active = 1'b0;
    logic         m_dz = 1'b0;
    logic         m_to = 1'b0;
    logic [W-1:0] m_q = '0, m_r = '0, m_ma = '0, m_mb = '0;
    int           m_e = 0, m_vedge = 0;

    always @(posedge clk) begin
        pe <= pe + 1;
        if (!reset) begin
            m_active <= 1'b0;
        end else if (!m_active) begin
            if (in_valid) begin
                m_active <= 1'b1;
                m_e      <= pe + 1;
                m_ma     <= mag(ext(in_signed, in_dividend));
                m_mb     <= mag(ext(in_signed, in_divisor));
                m_dz     <= (in_divisor == '0);
                m_to     <= (in_divisor != '0) && stuck;
                if (in_divisor == '0) begin
                    m_q     <= '1;
                    m_r     <= in_dividend;
                    m_vedge <= pe + 1;
                end else if (stuck) begin
                    m_q     <= '0;
                    m_r     <= '0;
                    m_vedge <= pe + 1 + TO + 1;
                end else begin
                    m_q     <= sdiv(ext(in_signed, in_dividend), ext(in_signed, in_divisor));
                    m_r     <= smod(ext(in_signed, in_dividend), ext(in_signed, in_divisor));
                    m_vedge <= pe + 1 + 67;
                end
            end
        end else if (pe >= m_vedge && out_ready) begin
            m_active <= 1'b0;
        end
    end

    int tests = 0;
    int fails = 0;
    logic done = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (pe > 0 && !done) begin
            chk("in_ready", {63'd0, in_ready}, {63'd0, !m_active});
            chk("out_valid", {63'd0, out_valid}, {63'd0, m_active && pe >= m_vedge});
            chk("core_start", {63'd0, core_start}, {63'd0, m_active && !m_dz && pe == m_e});
            if (m_active && pe >= m_vedge) begin
                chk("out_quotient", out_quotient, m_q);
                chk("out_remainder", out_remainder, m_r);
                chk("out_div_zero", {63'd0, out_div_zero}, {63'd0, m_dz});
                chk("out_timeout", {63'd0, out_timeout}, {63'd0, m_to});
            end
            if (m_active && !m_dz && pe >= m_e && pe < m_vedge) begin
                chk("core_dividend", core_dividend, m_ma);
                chk("core_divisor", core_divisor, m_mb);
            end
        end
    end

    task automatic run_op(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edz, input logic eto, input int elat, input int hold);
        int cyc;
        @(posedge clk); #1;
        in_valid = 1'b1; in_signed = sg; in_dividend = a; in_divisor = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(elat));
        repeat (hold) begin
            @(posedge clk); #1;
            in_valid = ~in_valid; in_dividend = 64'd9; in_divisor = 64'd2;
        end
        in_valid = 1'b0;
        chk("lit_quotient", out_quotient, eq);
        chk("lit_remainder", out_remainder, er);
        chk("lit_div_zero", {63'd0, out_div_zero}, {63'd0, edz});
        chk("lit_timeout", {63'd0, out_timeout}, {63'd0, eto});
        stuck = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("lit_back_idle", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_quotient", out_quotient, 64'd0);
        reset = 1'b1;

        run_op(1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0, 68, 0);
        run_op(1'b1, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 68, 0);
        run_op(1'b1, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 1'b0, 1'b0, 68, 0);
        run_op(1'b1, -64'sd100, -64'sd7, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 68, 0);
        run_op(1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b1, 1'b0, 1, 0);
        run_op(1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b0, 68, 0);
        run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0, 68, 0);
        run_op(1'b1, -64'sd3, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 68, 0);
        run_op(1'b0, 64'd1000, 64'd3, 64'd333, 64'd1, 1'b0, 1'b0, 68, 10);
        stuck = 1'b1;
        run_op(1'b1, 64'd5, 64'd3, 64'd0, 64'd0, 1'b0, 1'b1, TO + 2, 0);

        @(posedge clk); #1;
        in_valid = 1'b1; in_signed = 1'b0; in_dividend = 64'd100; in_divisor = 64'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("midop_reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midop_reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midop_reset_core_start", {63'd0, core_start}, 64'd0);

        run_op(1'b1, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0, 1'b0, 68, 0);

        @(posedge clk); #1;
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
